// File: rtl/cordic_pkg.sv
// Shared constants and encodings for the CORDIC core, its range reducer and their benches.
// Angles are signed Q16.16 radians.
package cordic_pkg;

  localparam logic signed [31:0] TWO_PI  = 32'sd411775;
  localparam logic signed [31:0] PI      = 32'sd205887;
  localparam logic signed [31:0] HALF_PI = 32'sd102944;
  localparam logic signed [31:0] K_GAIN  = 32'sd39797;

  typedef enum logic [2:0] {
    IDLE,
    REDUCE,
    WRAP,
    FOLD,
    OUT
  } state_t;

  localparam logic [1:0] QUAD_I   = 2'd0;  // [0, pi/2]
  localparam logic [1:0] QUAD_II  = 2'd1;  // (pi/2, pi]
  localparam logic [1:0] QUAD_III = 2'd2;  // [-pi, -pi/2)
  localparam logic [1:0] QUAD_IV  = 2'd3;  // [-pi/2, 0)

endpackage

// File: rtl/quadrant_fold.sv
// Combinational wrap/fold math: maps a magnitude in [0, 2pi) plus sign into [-pi, pi],
// and folds a [-pi, pi] angle into [-pi/2, pi/2] with a cosine-negate flag.
module quadrant_fold
  import cordic_pkg::*;
(
  input  logic        [31:0] a_in,
  input  logic               sign_in,
  output logic signed [31:0] z_wrap,
  input  logic signed [31:0] z_in,
  output logic signed [31:0] z_fold,
  output logic               cos_neg,
  output logic        [1:0]  quadrant
);

  logic signed [31:0] a_signed;

  always_comb begin
    a_signed = $signed(a_in);
    if (a_signed > PI) begin
      a_signed = a_signed - TWO_PI;
    end
    z_wrap = sign_in ? -a_signed : a_signed;
  end

  // Reflecting about +/-pi/2 keeps the sine and flips the cosine sign.
  always_comb begin
    z_fold   = z_in;
    cos_neg  = 1'b0;
    quadrant = QUAD_I;
    if (z_in > HALF_PI) begin
      z_fold   = PI - z_in;
      cos_neg  = 1'b1;
      quadrant = QUAD_II;
    end else if (z_in < -HALF_PI) begin
      z_fold   = -PI - z_in;
      cos_neg  = 1'b1;
      quadrant = QUAD_III;
    end else if (z_in[31]) begin
      quadrant = QUAD_IV;
    end
  end

endmodule

// File: rtl/cordic_range_reducer.sv
// Reduces an arbitrary Q16.16 angle into [-pi/2, pi/2] for a rotation-mode CORDIC core,
// using fixed-latency restoring division by 2pi followed by a quadrant fold.
module cordic_range_reducer
  import cordic_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int K_MAX = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] angle_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z_out,
  output logic [WIDTH-1:0] x0_out,
  output logic [WIDTH-1:0] y0_out,
  output logic             cos_neg,
  output logic [1:0]       quadrant
);

  localparam int K_W = $clog2(K_MAX + 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MOST_POS = {1'b0, {(WIDTH-1){1'b1}}};

  state_t state_reg, state_next;

  logic        [WIDTH-1:0] a_reg;
  logic                    sign_reg;
  logic        [K_W-1:0]   k_reg;
  logic signed [WIDTH-1:0] z_reg;
  logic                    cos_neg_reg;
  logic        [1:0]       quadrant_reg;

  logic        [WIDTH-1:0] a_abs;
  logic        [WIDTH:0]   step_val;
  logic                    step_take;
  logic signed [WIDTH-1:0] z_wrap;
  logic signed [WIDTH-1:0] z_fold;
  logic                    fold_cos_neg;
  logic        [1:0]       fold_quadrant;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = REDUCE;
      REDUCE:  if (k_reg == '0) state_next = WRAP;
      WRAP:    state_next = FOLD;
      FOLD:    state_next = OUT;
      OUT:     if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_reg == IDLE);
    out_valid = (state_reg == OUT);
  end

  // The most negative input has no positive twin, so it saturates.
  always_comb begin
    if (angle_in == MOST_NEG) begin
      a_abs = MOST_POS;
    end else if (angle_in[WIDTH-1]) begin
      a_abs = -angle_in;
    end else begin
      a_abs = angle_in;
    end
  end

  // Compare one bit wider so 2pi << k can never wrap.
  assign step_val  = {1'b0, TWO_PI} << k_reg;
  assign step_take = ({1'b0, a_reg} >= step_val);

  quadrant_fold u_fold (
    .a_in     (a_reg),
    .sign_in  (sign_reg),
    .z_wrap   (z_wrap),
    .z_in     (z_reg),
    .z_fold   (z_fold),
    .cos_neg  (fold_cos_neg),
    .quadrant (fold_quadrant)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg        <= '0;
      sign_reg     <= 1'b0;
      k_reg        <= '0;
      z_reg        <= '0;
      cos_neg_reg  <= 1'b0;
      quadrant_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            sign_reg <= angle_in[WIDTH-1];
            a_reg    <= a_abs;
            k_reg    <= K_W'(K_MAX);
          end
        end
        REDUCE: begin
          if (step_take) begin
            a_reg <= a_reg - step_val[WIDTH-1:0];
          end
          if (k_reg != '0) begin
            k_reg <= k_reg - 1'b1;
          end
        end
        WRAP: begin
          z_reg <= z_wrap;
        end
        FOLD: begin
          z_reg        <= z_fold;
          cos_neg_reg  <= fold_cos_neg;
          quadrant_reg <= fold_quadrant;
        end
        default: begin
        end
      endcase
    end
  end

  assign z_out    = z_reg;
  assign cos_neg  = cos_neg_reg;
  assign quadrant = quadrant_reg;
  assign x0_out   = K_GAIN;
  assign y0_out   = '0;

endmodule

// File: tb/tb_cordic_range_reducer.sv
// Directed bench for cordic_range_reducer: reset, reduction vectors, latency,
// backpressure, mid-flight reset and back-to-back transactions.
module tb_cordic_range_reducer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] angle_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] z_out;
  logic [31:0] x0_out;
  logic [31:0] y0_out;
  logic        cos_neg;
  logic [1:0]  quadrant;

  int total = 0;
  int bad   = 0;

  localparam int NV = 11;
  localparam int VEC_ANG [NV] = '{0, 205887, 458752, -131072, 32'h8000_0000, -205887,
                                  262144, 102944, -102944, 32'h7FFF_FFFF, 102945};
  localparam int VEC_Z   [NV] = '{0, 0, 46977, -74815, -77022, 0,
                                  -56256, 102944, -102944, 77022, 102942};
  localparam bit VEC_CN  [NV] = '{0, 1, 0, 1, 0, 1, 1, 0, 0, 0, 1};
  localparam int VEC_Q   [NV] = '{0, 1, 0, 2, 3, 2, 2, 0, 3, 0, 1};

  cordic_range_reducer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .angle_in  (angle_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z_out     (z_out),
    .x0_out    (x0_out),
    .y0_out    (y0_out),
    .cos_neg   (cos_neg),
    .quadrant  (quadrant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents one angle from IDLE and waits (bounded) for out_valid.
  task automatic run_angle(input logic [31:0] ang, output logic [31:0] z, output logic cn,
                           output logic [1:0] q, output int lat);
    angle_in = ang;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    z  = z_out;
    cn = cos_neg;
    q  = quadrant;
    $display("txn angle=%0d z=%0d cos_neg=%0b quadrant=%0d latency=%0d",
             $signed(ang), $signed(z), cn, q, lat);
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    in_valid = 1'b1;
    angle_in = 32'd458752;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++;
    if (z_out !== 32'd0) begin bad++; $display("FAIL reset_z got=%0d want=0", $signed(z_out)); end
    total++;
    if (cos_neg !== 1'b0 || quadrant !== 2'd0) begin
      bad++; $display("FAIL reset_flags got cos_neg=%b quadrant=%0d want 0/0", cos_neg, quadrant);
    end
    total++;
    if (x0_out !== 32'd39797 || y0_out !== 32'd0) begin
      bad++; $display("FAIL reset_init_vec got x0=%0d y0=%0d want 39797/0", x0_out, y0_out);
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_idle got=%b want=1", in_ready); end
  endtask

  task automatic test_angles();
    logic [31:0] z;
    logic        cn;
    logic [1:0]  q;
    int          lat;
    out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL vec%0d_in_ready got=%b want=1", i, in_ready); end
      run_angle(VEC_ANG[i], z, cn, q, lat);
      total++;
      if (lat !== 15) begin bad++; $display("FAIL vec%0d_latency got=%0d want=15", i, lat); end
      total++;
      if (z !== VEC_Z[i]) begin
        bad++; $display("FAIL vec%0d_z got=%0d want=%0d", i, $signed(z), VEC_Z[i]);
      end
      total++;
      if (cn !== VEC_CN[i]) begin bad++; $display("FAIL vec%0d_cos_neg got=%b want=%b", i, cn, VEC_CN[i]); end
      total++;
      if (q !== 2'(VEC_Q[i])) begin bad++; $display("FAIL vec%0d_quadrant got=%0d want=%0d", i, q, VEC_Q[i]); end
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        bad++; $display("FAIL vec%0d_pulse got out_valid=%b in_ready=%b want 0/1", i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] z;
    logic        cn;
    logic [1:0]  q;
    int          lat;
    bit          stable;
    out_ready = 1'b0;
    run_angle(32'd458752, z, cn, q, lat);
    total++;
    if (lat !== 15 || z !== 32'd46977) begin
      bad++; $display("FAIL bp_first got lat=%0d z=%0d want 15/46977", lat, $signed(z));
    end
    stable = 1'b1;
    for (int c = 0; c < 20; c++) begin
      in_valid = 1'b1;
      angle_in = 32'hFFFE_0000;
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || z_out !== 32'd46977 ||
          cos_neg !== 1'b0 || quadrant !== 2'd0) stable = 1'b0;
    end
    in_valid = 1'b0;
    total++;
    if (stable !== 1'b1) begin
      bad++; $display("FAIL bp_hold got out_valid=%b in_ready=%b z=%0d want 1/0/46977",
                      out_valid, in_ready, $signed(z_out));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL bp_release got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ignored_input got in_ready=%b want 1", in_ready); end
  endtask

  task automatic test_reset_mid_reduce();
    bit quiet;
    out_ready = 1'b1;
    angle_in  = 32'd458752;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL mid_busy got in_ready=%b want 0", in_ready); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL mid_reset got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
    total++;
    if (z_out !== 32'd0 || cos_neg !== 1'b0 || quadrant !== 2'd0) begin
      bad++; $display("FAIL mid_reset_data got z=%0d cos_neg=%b quadrant=%0d want 0/0/0",
                      $signed(z_out), cos_neg, quadrant);
    end
    quiet = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) quiet = 1'b0;
    end
    total++;
    if (quiet !== 1'b1) begin bad++; $display("FAIL mid_stale got stale out_valid want none"); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] z;
    logic        cn;
    logic [1:0]  q;
    int          lat;
    out_ready = 1'b1;
    run_angle(32'hFFFE_0000, z, cn, q, lat);
    total++;
    if (z !== 32'hFFFE_DBC1 || cn !== 1'b1 || q !== 2'd2) begin
      bad++; $display("FAIL b2b_first got z=%0d cos_neg=%b quadrant=%0d want -74815/1/2", $signed(z), cn, q);
    end
    @(posedge clk); #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%b want=1", in_ready); end
    run_angle(32'd262144, z, cn, q, lat);
    total++;
    if (lat !== 15 || z !== 32'hFFFF_2440 || cn !== 1'b1 || q !== 2'd2) begin
      bad++; $display("FAIL b2b_second got lat=%0d z=%0d cos_neg=%b quadrant=%0d want 15/-56256/1/2",
                      lat, $signed(z), cn, q);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    angle_in  = '0;
    out_ready = 1'b1;
    test_reset();
    test_angles();
    test_backpressure();
    test_reset_mid_reduce();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cordic_range_reducer.md
# cordic_range_reducer

Upstream pre-processing stage for the `cordic` core in CIRCULAR/ROTATION mode. It accepts an arbitrary signed Q16.16 angle in radians and reduces it to the core's convergence range [-π/2, π/2]. It emits the reduced angle together with the fixed initial vector (x0 = K, y0 = 0) and a cosine-negate flag, which the consumer applies to `x_out`. The angle is reduced by fixed-latency binary long division by 2π followed by a quadrant fold, with valid/ready handshakes on both sides.

## Interface
- WIDTH, 32, data width; Q16.16 signed. Only 32 is supported.
- K_MAX, 12, index of the largest shift step (2π·2^12 < 2^31).
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  angle_in is valid
- in_ready  out  1  block is idle and can accept an angle
- angle_in  in  WIDTH  signed Q16.16 angle in radians
- out_valid  out  1  reduced result is valid; held until it is accepted
- out_ready  in  1  consumer accepts the result
- z_out  out  WIDTH  reduced angle, signed Q16.16, in [-102944, 102944]
- x0_out  out  WIDTH  constant K = 39797 (0.60725)
- y0_out  out  WIDTH  constant 0
- cos_neg  out  1  consumer must negate the CORDIC x result
- quadrant  out  2  0: [0, π/2]; 1: (π/2, π]; 2: [-π, -π/2); 3: [-π/2, 0)

## Operation
- Constants, all Q16.16: TWO_PI = 411775, PI = 205887, HALF_PI = 102944, K = 39797.
- States and transitions:
  - IDLE → REDUCE on in_valid && in_ready.
  - REDUCE → REDUCE for K_MAX+1 cycles, then → WRAP.
  - WRAP → FOLD → OUT.
  - OUT → IDLE on out_ready.
- IDLE:
  - in_ready = 1, decoded from state.
  - On accept, capture sign s = angle_in[31] and a = |angle_in|.
  - 0x80000000 saturates to 0x7FFFFFFF.
  - Load step counter k = K_MAX.
- REDUCE, one step per cycle:
  - If a ≥ (TWO_PI << k), then a -= TWO_PI << k.
  - Decrement k; leave the state after k = 0.
  - Compare in 33-bit unsigned so the shifted constant cannot overflow.
  - On exit, a is in [0, TWO_PI).
- WRAP:
  - If a > PI, then a -= TWO_PI.
  - z = s ? -a : a.
  - Result z is in [-PI, PI].
- FOLD:
  - If z > HALF_PI: z = PI − z, cos_neg = 1, quadrant = 1.
  - Else if z < −HALF_PI: z = −PI − z, cos_neg = 1, quadrant = 2.
  - Else: cos_neg = 0; quadrant = 0 if z ≥ 0, otherwise 3.
  - The sine sign is never changed, because sin(±π − z) = sin z.
- OUT:
  - out_valid = 1; z_out, cos_neg and quadrant are stable.
  - in_ready = 0.
  - On out_valid && out_ready, return to IDLE.
- x0_out and y0_out are constant drivers and do not depend on state.

## Timing
- Acceptance happens at edge T0.
- out_valid rises after edge T0 + K_MAX + 3, i.e. T0 + 15: 13 REDUCE cycles, then WRAP, then FOLD.
- Earliest next accept is the cycle after the output is accepted; one result every 17 cycles or more.
- Backpressure: while out_ready = 0, out_valid and all data hold indefinitely.
- in_valid is ignored whenever in_ready = 0. There is no buffering.
- rst, including mid-REDUCE or mid-OUT, takes effect at the next edge:
  - state returns to IDLE, so in_ready = 1 after the reset edge;
  - out_valid, z_out, cos_neg, quadrant and k reset to 0;
  - any in-flight result is discarded.
- in_valid high in the same cycle as rst is not accepted.

## Structure
- `cordic_pkg` holds TWO_PI, PI, HALF_PI, K_GAIN, the state enum {IDLE, REDUCE, WRAP, FOLD, OUT} and the quadrant encodings. The CORDIC core and its bench share these constants.
- One sub-module is natural: `quadrant_fold`, a combinational unit covering the WRAP+FOLD math (z in, z/cos_neg/quadrant out) so it can be unit-tested in isolation.
- Single clock domain, no memories.

## Test plan
- angle 0, out_ready = 1:
  - z_out = 0, quadrant 0, cos_neg 0;
  - out_valid 15 cycles after accept, for exactly 1 cycle.
- angle 205887 (π): z_out = 0, cos_neg 1, quadrant 1.
- angle 458752 (7.0 rad): z_out = 46977, cos_neg 0, quadrant 0.
- angle −131072 (−2.0 rad): z_out = −74815, cos_neg 1, quadrant 2.
- angle 0x80000000: saturates, then z_out = −77022, cos_neg 0, quadrant 3.
- Backpressure:
  - hold out_ready = 0 for 20 cycles → out_valid and data stable, in_ready = 0, new in_valid ignored.
  - Separately, assert rst at REDUCE step 5 → next cycle IDLE, out_valid = 0, in_ready = 1, no stale result emitted.
